countdown_controller: RTL and testbench
=======================================

# countdown_controller

Sequencing controller for the M:SS countdown datapath: it turns raw start/pause and clear buttons into load, tick, and clear commands for the seconds/tens/minutes down-counters, and raises an alarm on expiry. It sits between the board buttons/switches and the counter datapath, replacing free-running enable wiring with a start/pause/expire state machine. It also owns the 1 Hz prescaler, so the datapath advances only on single-cycle `dp_tick` pulses in the 100 MHz domain.

## Interface
- `TICK_DIV`, 100_000_000: clk_100MHz cycles per countdown second; set to 10 in simulation.
- `SYNC_STAGES`, 2: flip-flop stages on each button synchronizer.
- `ALARM_SECONDS`, 10: ticks spent in EXPIRED before automatic return to IDLE.
- `clk_100MHz`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `btn_start`  in  1  raw start/pause button, asynchronous, pre-debounced.
- `btn_clear`  in  1  raw clear button, asynchronous, pre-debounced.
- `start_minutes`  in  2  initial minutes value, static while IDLE.
- `all_zero`  in  1  datapath count == 0:00, registered in the datapath.
- `dp_load`  out  1  one-cycle pulse; datapath loads `load_value`:00.
- `load_value`  out  2  minutes captured from `start_minutes` at start.
- `dp_tick`  out  1  one-cycle decrement strobe.
- `dp_clear`  out  1  one-cycle pulse; datapath forced to 0:00.
- `alarm`  out  1  high throughout EXPIRED.
- `state`  out  2  IDLE=0, RUNNING=1, PAUSED=2, EXPIRED=3.

## Operation
- Each button passes through a `SYNC_STAGES` synchronizer and a rising-edge detector, giving `start_p` and `clear_p` (one cycle per press).
- Priority in every state: `clear_p` > `all_zero` (RUNNING only) > `start_p`.
- **IDLE.**
  - `start_p` with `start_minutes` ≠ 0 → RUNNING; same edge: `dp_load`=1, `load_value`=`start_minutes`, prescaler cleared.
  - `start_p` with `start_minutes` = 0 is ignored.
  - `clear_p` → stay IDLE, pulse `dp_clear`.
- **RUNNING.**
  - `clear_p` → IDLE with `dp_clear`.
  - `all_zero` = 1 → EXPIRED; no tick is issued that cycle.
  - `start_p` → PAUSED.
  - Otherwise, on prescaler wrap, `dp_tick`=1.
- **PAUSED.**
  - Prescaler holds its value, so the partial second is preserved.
  - `start_p` → RUNNING with no load.
  - `clear_p` → IDLE with `dp_clear`.
- **EXPIRED.**
  - `alarm`=1. The prescaler runs and each wrap increments an alarm counter, but `dp_tick` stays 0.
  - When the alarm counter reaches `ALARM_SECONDS` → IDLE.
  - `start_p` or `clear_p` → IDLE immediately; `clear_p` also pulses `dp_clear`.
- **Prescaler.**
  - Width `$clog2(TICK_DIV)`.
  - Counts 0..`TICK_DIV`-1 and wraps in RUNNING/EXPIRED; holds in PAUSED; is 0 in IDLE.
  - Wrap means count == `TICK_DIV`-1.
- **Alarm counter.** Width `$clog2(ALARM_SECONDS+1)`, cleared on EXPIRED entry.

## Timing
- **Reset values:** `state`=IDLE; `dp_load`, `dp_tick`, `dp_clear`, `alarm`, `load_value` all 0; prescaler, alarm counter and synchronizers 0.
- All outputs are registered.
- Button edge to `start_p`/`clear_p`: `SYNC_STAGES`+1 cycles.
- `start_p`/`clear_p` to output pulse or state change: 1 cycle.
- The datapath applies `dp_load` on the same edge the state enters RUNNING, so the first RUNNING cycle sees the loaded `all_zero`=0.
- First `dp_tick` comes `TICK_DIV` cycles after `dp_load`; thereafter exactly every `TICK_DIV` running cycles, excluding paused cycles.
- `all_zero` rising in RUNNING → `state`=EXPIRED and `alarm`=1 on the next edge.
- **Reset mid-operation:** everything clears asynchronously; the datapath is reset by its own reset.
- A button held high produces exactly one pulse; the button must be released and pressed again for another.

## Structure
- Shared package `countdown_pkg`: state encoding constants (IDLE, RUNNING, PAUSED, EXPIRED), 2-bit state width.
- One sub-module, `button_sync_edge` (parameter `SYNC_STAGES`; ports clk, reset, async_in, pulse_out), instantiated twice.
- FSM, prescaler and alarm counter live in `countdown_controller`.

## Test plan
(All scenarios use `TICK_DIV`=10, `ALARM_SECONDS`=3.)
- **Normal run:** `start_minutes`=2, press start → one `dp_load` with `load_value`=2, `state`=RUNNING; `dp_tick` every 10 cycles; no other pulses.
- **Pause/resume:** press start 4 cycles after a tick → PAUSED, no ticks for 50 cycles; resume → next tick 6 running cycles later.
- **Expiry:** drive `all_zero`=1 in RUNNING → EXPIRED next cycle, `alarm`=1, no `dp_tick`; IDLE after 3 prescaler wraps (30 cycles), `alarm`=0.
- **Clear priority:** `btn_start` and `btn_clear` rise together in RUNNING → one `dp_clear`, `state`=IDLE, no PAUSED.
- **Zero start:** `start_minutes`=0, press start → state stays IDLE, no `dp_load`; a held button gives a single edge only.
- **Async reset mid-run:** assert `reset` between clock edges in RUNNING → `state`=0 and all outputs 0 before the next edge; after release, the prescaler restarts from 0.

Source files
------------

// File: rtl/countdown_pkg.sv
// countdown_pkg
//   Shared definitions for the M:SS countdown controller: the controller
//   state encoding and its width. The encoding is visible on the `state`
//   output, so the numeric values are fixed.
package countdown_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

endpackage : countdown_pkg

// File: rtl/button_sync_edge.sv
// button_sync_edge
//   Brings an asynchronous, pre-debounced button into the clock domain and
//   turns each rising edge into a single-cycle pulse. Holding the button
//   high produces one pulse only; it must fall and rise again for another.
//   Latency from the input edge to pulse_out is SYNC_STAGES+1 cycles.
// Ports:
//   clk       in  clock
//   reset     in  asynchronous active-high reset
//   async_in  in  raw button level
//   pulse_out out registered one-cycle pulse per rising edge
module button_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse_out
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   pulse_q, pulse_d;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = async_in;
    prev_d    = sync_q[SYNC_STAGES-1];
    pulse_d   = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_out = pulse_q;

endmodule : button_sync_edge

// File: rtl/countdown_controller.sv
// countdown_controller
//   Start/pause/expire sequencer for the M:SS countdown datapath. Converts the
//   start/pause and clear buttons into load, tick and clear commands, owns the
//   1 Hz prescaler and raises the alarm on expiry.
//   All command outputs are registered single-cycle pulses with no handshake:
//   the datapath must act on every cycle in which a pulse is high.
// Ports:
//   clk_100MHz    in   sole clock
//   reset         in   asynchronous active-high reset
//   btn_start     in   raw start/pause button
//   btn_clear     in   raw clear button
//   start_minutes in   [1:0] minutes to load on start
//   all_zero      in   datapath count is 0:00
//   dp_load       out  load pulse, datapath loads load_value:00
//   load_value    out  [1:0] minutes captured at start
//   dp_tick       out  one-second decrement strobe
//   dp_clear      out  clear pulse, datapath forced to 0:00
//   alarm         out  high throughout EXPIRED
//   state         out  [1:0] current FSM state (IDLE/RUNNING/PAUSED/EXPIRED)
module countdown_controller
  import countdown_pkg::*;
#(
  parameter int TICK_DIV      = 100_000_000,
  parameter int SYNC_STAGES   = 2,
  parameter int ALARM_SECONDS = 10
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               btn_start,
  input  logic               btn_clear,
  input  logic [1:0]         start_minutes,
  input  logic               all_zero,
  output logic               dp_load,
  output logic [1:0]         load_value,
  output logic               dp_tick,
  output logic               dp_clear,
  output logic               alarm,
  output logic [STATE_W-1:0] state
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ALARM_W = $clog2(ALARM_SECONDS + 1);

  logic start_p, clear_p;

  button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
    .clk       (clk_100MHz),
    .reset     (reset),
    .async_in  (btn_start),
    .pulse_out (start_p)
  );

  button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clear (
    .clk       (clk_100MHz),
    .reset     (reset),
    .async_in  (btn_clear),
    .pulse_out (clear_p)
  );

  state_t               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [ALARM_W-1:0]   alarm_cnt_q, alarm_cnt_d;
  logic [1:0]           load_value_q, load_value_d;
  logic                 dp_load_q, dp_load_d;
  logic                 dp_tick_q, dp_tick_d;
  logic                 dp_clear_q, dp_clear_d;
  logic                 alarm_q, alarm_d;

  logic                 presc_wrap;
  logic [PRESC_W-1:0]   presc_inc;
  logic [ALARM_W-1:0]   alarm_cnt_inc;

  assign presc_wrap    = (presc_q == PRESC_W'(TICK_DIV - 1));
  assign presc_inc     = presc_q + 1'b1;
  assign alarm_cnt_inc = alarm_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    alarm_cnt_d  = alarm_cnt_q;
    load_value_d = load_value_q;
    dp_load_d    = 1'b0;
    dp_tick_d    = 1'b0;
    dp_clear_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        if (clear_p) begin
          dp_clear_d = 1'b1;
        end else if (start_p && (start_minutes != 2'd0)) begin
          state_d      = RUNNING;
          dp_load_d    = 1'b1;
          load_value_d = start_minutes;
        end
      end

      RUNNING: begin
        if (clear_p) begin
          state_d    = IDLE;
          dp_clear_d = 1'b1;
          presc_d    = '0;
        end else if (all_zero) begin
          state_d     = EXPIRED;
          presc_d     = '0;
          alarm_cnt_d = '0;
        end else if (start_p) begin
          // The pausing cycle still counts as a running cycle, but a wrap
          // falling on it is held back so the tick is issued after resume
          // rather than lost.
          state_d = PAUSED;
          presc_d = presc_wrap ? presc_q : presc_inc;
        end else if (presc_wrap) begin
          presc_d   = '0;
          dp_tick_d = 1'b1;
        end else begin
          presc_d = presc_inc;
        end
      end

      PAUSED: begin
        if (clear_p) begin
          state_d    = IDLE;
          dp_clear_d = 1'b1;
          presc_d    = '0;
        end else if (start_p) begin
          state_d = RUNNING;
        end
      end

      EXPIRED: begin
        if (clear_p) begin
          state_d    = IDLE;
          dp_clear_d = 1'b1;
          presc_d    = '0;
        end else if (start_p) begin
          state_d = IDLE;
          presc_d = '0;
        end else if (presc_wrap) begin
          presc_d     = '0;
          alarm_cnt_d = alarm_cnt_inc;
          if (alarm_cnt_inc == ALARM_W'(ALARM_SECONDS)) state_d = IDLE;
        end else begin
          presc_d = presc_inc;
        end
      end
    endcase

    alarm_d = (state_d == EXPIRED);
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      alarm_cnt_q  <= '0;
      load_value_q <= 2'd0;
      dp_load_q    <= 1'b0;
      dp_tick_q    <= 1'b0;
      dp_clear_q   <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      alarm_cnt_q  <= alarm_cnt_d;
      load_value_q <= load_value_d;
      dp_load_q    <= dp_load_d;
      dp_tick_q    <= dp_tick_d;
      dp_clear_q   <= dp_clear_d;
      alarm_q      <= alarm_d;
    end
  end

  assign dp_load    = dp_load_q;
  assign load_value = load_value_q;
  assign dp_tick    = dp_tick_q;
  assign dp_clear   = dp_clear_q;
  assign alarm      = alarm_q;
  assign state      = state_q;

endmodule : countdown_controller

// File: tb/tb_countdown_controller.sv
// tb_countdown_controller
//   Directed bench for countdown_controller with TICK_DIV=10, ALARM_SECONDS=3.
//   Inputs change 1 ns after the rising edge; outputs are checked at that
//   point, and a falling-edge monitor counts output pulses.
module tb_countdown_controller;

  logic       clk_100MHz = 1'b0;
  logic       reset;
  logic       btn_start;
  logic       btn_clear;
  logic [1:0] start_minutes;
  logic       all_zero;
  logic       dp_load;
  logic [1:0] load_value;
  logic       dp_tick;
  logic       dp_clear;
  logic       alarm;
  logic [1:0] state;

  countdown_controller #(
    .TICK_DIV      (10),
    .SYNC_STAGES   (2),
    .ALARM_SECONDS (3)
  ) dut (
    .clk_100MHz    (clk_100MHz),
    .reset         (reset),
    .btn_start     (btn_start),
    .btn_clear     (btn_clear),
    .start_minutes (start_minutes),
    .all_zero      (all_zero),
    .dp_load       (dp_load),
    .load_value    (load_value),
    .dp_tick       (dp_tick),
    .dp_clear      (dp_clear),
    .alarm         (alarm),
    .state         (state)
  );

  // ---------------- clock / cycle stamp ----------------
  always #5 clk_100MHz = ~clk_100MHz;

  int cyc = 0;
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  // ---------------- pulse monitor ----------------
  int n_load = 0, n_tick = 0, n_clear = 0, n_paused = 0;
  int last_tick_cyc = 0, tick_gap = 0;

  always @(negedge clk_100MHz) begin
    if (!reset) begin
      if (dp_load)        n_load++;
      if (dp_clear)       n_clear++;
      if (state == 2'd2)  n_paused++;
      if (dp_tick) begin
        n_tick++;
        tick_gap      = cyc - last_tick_cyc;
        last_tick_cyc = cyc;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  // Press for four cycles: the FSM reacts on the fourth edge after the press,
  // so on return the caller sits in the first cycle showing the reaction.
  task automatic press(input logic s, input logic c);
    btn_start = s;
    btn_clear = c;
    wait_cycles(4);
    btn_start = 1'b0;
    btn_clear = 1'b0;
  endtask

  int l0, t0, c0, p0;

  initial begin
    reset         = 1'b1;
    btn_start     = 1'b0;
    btn_clear     = 1'b0;
    start_minutes = 2'd0;
    all_zero      = 1'b0;
    wait_cycles(3);

    // Reset values
    check("rst_state",      state,      0);
    check("rst_dp_load",    dp_load,    0);
    check("rst_dp_tick",    dp_tick,    0);
    check("rst_dp_clear",   dp_clear,   0);
    check("rst_alarm",      alarm,      0);
    check("rst_load_value", load_value, 0);
    reset = 1'b0;
    wait_cycles(2);

    // Normal run
    start_minutes = 2'd2;
    l0 = n_load; c0 = n_clear;
    press(1'b1, 1'b0);
    check("run_state",      state,      1);
    check("run_dp_load",    dp_load,    1);
    check("run_load_value", load_value, 2);
    wait_cycles(9);
    check("run_no_tick_9",  dp_tick,    0);
    wait_cycles(1);
    check("run_tick_10",    dp_tick,    1);
    wait_cycles(10);
    check("run_tick_20",    dp_tick,    1);
    exp_q.push_back(32'd10);
    wait_cycles(1);
    check("run_tick_gap",   tick_gap,   exp_q.pop_front());
    check("run_one_load",   n_load - l0, 1);
    check("run_no_clear",   n_clear - c0, 0);

    // Pause four cycles after the last tick, then resume
    press(1'b1, 1'b0);
    check("pause_state",    state,      2);
    check("pause_no_tick",  dp_tick,    0);
    t0 = n_tick;
    wait_cycles(50);
    check("pause_hold_state", state,    2);
    check("pause_no_ticks", n_tick - t0, 0);
    press(1'b1, 1'b0);
    check("resume_state",   state,      1);
    check("resume_no_load", dp_load,    0);
    wait_cycles(4);
    check("resume_no_tick_5", dp_tick,  0);
    wait_cycles(1);
    check("resume_tick_6",  dp_tick,    1);

    // Expiry
    all_zero = 1'b1;
    wait_cycles(1);
    check("exp_state",      state,      3);
    check("exp_alarm",      alarm,      1);
    check("exp_no_tick",    dp_tick,    0);
    t0 = n_tick;
    wait_cycles(29);
    check("exp_state_29",   state,      3);
    check("exp_alarm_29",   alarm,      1);
    wait_cycles(1);
    check("exp_idle_30",    state,      0);
    check("exp_alarm_off",  alarm,      0);
    check("exp_no_ticks",   n_tick - t0, 0);
    all_zero = 1'b0;

    // Clear beats start when both rise together
    start_minutes = 2'd1;
    press(1'b1, 1'b0);
    check("clr_run_state",  state,      1);
    check("clr_load_value", load_value, 1);
    wait_cycles(3);
    c0 = n_clear; p0 = n_paused;
    press(1'b1, 1'b1);
    check("clr_state",      state,      0);
    check("clr_dp_clear",   dp_clear,   1);
    wait_cycles(3);
    check("clr_one_clear",  n_clear - c0, 1);
    check("clr_no_pause",   n_paused - p0, 0);

    // Zero start is ignored
    start_minutes = 2'd0;
    l0 = n_load;
    press(1'b1, 1'b0);
    check("zero_state",     state,      0);
    check("zero_dp_load",   dp_load,    0);
    wait_cycles(3);
    check("zero_no_load",   n_load - l0, 0);

    // A held button gives exactly one start pulse
    start_minutes = 2'd1;
    p0 = n_paused;
    btn_start = 1'b1;
    wait_cycles(4);
    check("held_state",     state,      1);
    wait_cycles(30);
    check("held_still_run", state,      1);
    check("held_no_pause",  n_paused - p0, 0);
    btn_start = 1'b0;
    wait_cycles(3);
    press(1'b0, 1'b1);
    check("held_cleared",   state,      0);
    wait_cycles(3);

    // Asynchronous reset mid-run
    start_minutes = 2'd2;
    press(1'b1, 1'b0);
    wait_cycles(7);
    check("arst_pre_state", state,      1);
    check("arst_pre_lv",    load_value, 2);
    #3 reset = 1'b1;
    #1;
    check("arst_state",      state,      0);
    check("arst_load_value", load_value, 0);
    check("arst_dp_load",    dp_load,    0);
    check("arst_dp_tick",    dp_tick,    0);
    check("arst_dp_clear",   dp_clear,   0);
    check("arst_alarm",      alarm,      0);
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(2);
    press(1'b1, 1'b0);
    check("arst_reload",    dp_load,    1);
    wait_cycles(9);
    check("arst_no_tick_9", dp_tick,    0);
    wait_cycles(1);
    check("arst_tick_10",   dp_tick,    1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule : tb_countdown_controller
